bus_arbiter4: RTL

- Round-robin arbiter granting one of four bus masters access to the shared slave bus.
- The combined slave acknowledge (OR of the per-slave acks) ends each transfer.
- Sits between the four master request lines and the bus mux select.
- Only one master owns the bus at a time; a one-cycle turnaround follows every transfer.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/bus_arbiter4_rr_select.sv | 14 +
 rtl/bus_arbiter4.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types, level constants and the rotate-priority pick function
// used by the four-master bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  localparam int NREQ = 4;

  // Bus levels for request, grant and acknowledge lines (active-low).
  localparam logic LVL_ASSERT = 1'b0;
  localparam logic LVL_NEGATE = 1'b1;

  // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req,
                                         input logic [1:0]      ptr);
    logic [2:0] r;
    logic [1:0] k;
    r = 3'b000;
    // Walk from the farthest offset back so the nearest hit overwrites.
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) r = {1'b1, k};
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_select.sv
// Combinational rotate-priority encoder: active-high requests in,
// first requester at or after ptr out.
module rr_select
  import arb_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  assign {valid_o, idx_o} = rr_pick(req_i, ptr_i);

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for four bus masters with one-cycle turnaround.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0n,
  input  logic       req1n,
  input  logic       req2n,
  input  logic       req3n,
  input  logic       ackn,
  output logic       gnt0n,
  output logic       gnt1n,
  output logic       gnt2n,
  output logic       gnt3n,
  output logic [1:0] owner,
  output logic       busy,
  output logic       tmo
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic [3:0] gntn_q, gntn_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;

  logic [3:0] req_act;
  logic       ack;
  logic       owner_req;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       rel_normal;
  logic       tmo_hit;

  assign req_act   = {req3n == LVL_ASSERT, req2n == LVL_ASSERT,
                      req1n == LVL_ASSERT, req0n == LVL_ASSERT};
  assign ack       = (ackn == LVL_ASSERT);
  assign owner_req = req_act[owner_q];
  // Ack and owner withdrawal both count as an ordinary completion.
  assign rel_normal = ack || !owner_req;

  rr_select u_sel (
    .req_i   (req_act),
    .ptr_i   (ptr_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == GRANT) && (cnt_q == TMO_LAST) && !rel_normal;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (state_q == GRANT && !ack) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_LAST;
  assign tmo_hit        = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      gntn_q  <= {NREQ{LVL_NEGATE}};
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gntn_q  <= gntn_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_valid) state_d = GRANT;
      GRANT:   if (rel_normal || tmo_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gntn_d  = gntn_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          gntn_d          = {NREQ{LVL_NEGATE}};
          gntn_d[sel_idx] = LVL_ASSERT;
          owner_d         = sel_idx;
          busy_d          = 1'b1;
        end
      end
      GRANT: begin
        if (rel_normal || tmo_hit) begin
          gntn_d = {NREQ{LVL_NEGATE}};
          busy_d = 1'b0;
          ptr_d  = owner_q + 2'd1;
          tmo_d  = tmo_hit;
        end
      end
      RELEASE: begin
        gntn_d = {NREQ{LVL_NEGATE}};
        busy_d = 1'b0;
      end
      default: begin
        gntn_d = {NREQ{LVL_NEGATE}};
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt0n = gntn_q[0];
  assign gnt1n = gntn_q[1];
  assign gnt2n = gntn_q[2];
  assign gnt3n = gntn_q[3];
  assign owner = owner_q;
  assign busy  = busy_q;
  assign tmo   = tmo_q;

endmodule
